gcd_stream_engine: RTL and testbench

- Parametrised successor of the LA-driven sequential GCD unit in the user project area.
- Computes GCD of two unsigned WIDTH-bit operands with binary (Stein) shift/subtract iteration, so there is no divider.
- Uses a valid/ready handshake on input and output, holds its result until consumed, reports iteration count, and supports abort.
- Sits between the Wishbone/LA front end in user_proj_example and the result path to LA/GPIO.

---
 rtl/gcd_if.sv | 26 ++
 rtl/gcd_stream_engine.sv | 115 +++++++++++
 tb/tb_gcd_stream_engine.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/gcd_if.sv
// Handshake bundle between the operand producer, the GCD engine and the result consumer.
interface gcd_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             abort_i;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] gcd_o;
    logic [CNT_W-1:0] cycles_o;
    logic             busy_o;

    modport master (
        output in_valid, a_i, b_i, abort_i, res_ready,
        input  in_ready, res_valid, gcd_o, cycles_o, busy_o
    );

    modport slave (
        input  in_valid, a_i, b_i, abort_i, res_ready,
        output in_ready, res_valid, gcd_o, cycles_o, busy_o
    );
endinterface

// File: rtl/gcd_stream_engine.sv
// Binary (Stein) GCD engine: strips common factors of two, then shift/subtract reduces
// until both operands match. Result and iteration count are held until consumed.
module gcd_stream_engine #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    gcd_if.slave  bus
);
    localparam int KW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, COMMON, REDUCE, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cyc_q, cyc_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            gcd_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            gcd_q   <= gcd_d;
            cyc_q   <= cyc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        gcd_d   = gcd_q;
        cyc_d   = cyc_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d   = bus.a_i;
                    b_d   = bus.b_i;
                    k_d   = '0;
                    cnt_d = '0;
                    // A zero operand makes the answer the other operand; skip iteration.
                    if (bus.a_i == '0 || bus.b_i == '0) begin
                        gcd_d   = bus.a_i | bus.b_i;
                        cyc_d   = '0;
                        state_d = DONE;
                    end else begin
                        state_d = COMMON;
                    end
                end
            end
            COMMON: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (!a_q[0] && !b_q[0]) begin
                        a_d = a_q >> 1;
                        b_d = b_q >> 1;
                        k_d = k_q + KW'(1);
                    end else begin
                        state_d = REDUCE;
                    end
                end
            end
            REDUCE: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (a_q == b_q) begin
                        gcd_d   = a_q << k_q;
                        cyc_d   = cnt_inc;
                        state_d = DONE;
                    end else if (!a_q[0]) begin
                        a_d = a_q >> 1;
                    end else if (!b_q[0]) begin
                        b_d = b_q >> 1;
                    end else if (a_q > b_q) begin
                        // both odd here, so the difference is even and halving is exact
                        a_d = (a_q - b_q) >> 1;
                    end else begin
                        b_d = (b_q - a_q) >> 1;
                    end
                end
            end
            DONE: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy_o    = (state_q == COMMON) || (state_q == REDUCE);
    assign bus.res_valid = (state_q == DONE);
    assign bus.gcd_o     = gcd_q;
    assign bus.cycles_o  = cyc_q;
endmodule

// File: tb/tb_gcd_stream_engine.sv
// Directed bench for gcd_stream_engine: Euclid-based reference model plus per-cycle scoreboard.
module tb_gcd_stream_engine;
    localparam int W  = 32;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gcd_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    gcd_if #(.WIDTH(W), .CNT_W(4))  bus2 ();

    gcd_stream_engine #(.WIDTH(W), .CNT_W(CW)) dut     (.clk(clk), .rst_n(rst_n), .bus(bus));
    gcd_stream_engine #(.WIDTH(W), .CNT_W(4))  dut_sat (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [W-1:0] g;
        int           c;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // GCD from Euclid's remainder loop; cycle count from the shift/subtract rules.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input int cw,
                                  output logic [W-1:0] g, output int cyc);
        logic [W-1:0] x, y, t;
        int n, mx;
        x = a; y = b;
        while (y != '0) begin
            t = x % y; x = y; y = t;
        end
        g = x;
        if (a == '0 || b == '0) begin
            cyc = 0;
        end else begin
            x = a; y = b; n = 0;
            while (!x[0] && !y[0]) begin
                x = x >> 1; y = y >> 1; n++;
            end
            n++;
            while (1'b1) begin
                n++;
                if (x == y) break;
                if (!x[0]) x = x >> 1;
                else if (!y[0]) y = y >> 1;
                else if (x > y) x = (x - y) >> 1;
                else y = (y - x) >> 1;
            end
            mx = (1 << cw) - 1;
            cyc = (n > mx) ? mx : n;
        end
    endfunction

    // Scoreboard: every cycle with a result showing must match the oldest expectation.
    logic prev_hs = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hs <= 1'b0;
        end else begin
            chk("one_state", 64'(int'(bus.in_ready) + int'(bus.busy_o) + int'(bus.res_valid)), 64'd1);
            if (prev_hs) chk("idle_after_hs", {bus.res_valid, bus.in_ready}, 2'b01);
            if (bus.res_valid) begin
                chk("result_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    chk("gcd_o", bus.gcd_o, q[0].g);
                    chk("cycles_o", bus.cycles_o, 64'(q[0].c));
                end
            end
            prev_hs <= bus.res_valid && bus.res_ready;
            if (bus.res_valid && bus.res_ready && q.size() != 0) void'(q.pop_front());
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_res);
        int n = 0;
        exp_t e;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_before_send", bus.in_ready, 1);
        if (expect_res) begin
            model(a, b, CW, e.g, e.c);
            q.push_back(e);
        end
        bus.in_valid = 1'b1; bus.a_i = a; bus.b_i = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output logic [W-1:0] g, output logic [CW-1:0] c);
        int n = 0;
        while (!(bus.res_valid && bus.res_ready) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("done_timeout", n < 300, 1);
        g = bus.gcd_o; c = bus.cycles_o;
        @(posedge clk); #1;
    endtask

    logic [W-1:0]  g;
    logic [CW-1:0] c;
    logic [W-1:0]  mg;
    int            mc;

    initial begin
        bus.in_valid = 0; bus.a_i = '0; bus.b_i = '0; bus.abort_i = 0; bus.res_ready = 1;
        bus2.in_valid = 0; bus2.a_i = '0; bus2.b_i = '0; bus2.abort_i = 0; bus2.res_ready = 1;

        // model pinned against hand-worked cases
        model(32'd48, 32'd18, CW, mg, mc);  chk("model_48_18", {mg, 32'(mc)}, {32'd6, 32'd7});
        model(32'd12, 32'd8, CW, mg, mc);   chk("model_12_8", {mg, 32'(mc)}, {32'd4, 32'd6});
        model(32'd9, 32'd6, CW, mg, mc);    chk("model_9_6", {mg, 32'(mc)}, {32'd3, 32'd4});
        model(32'hFFFF_FFFF, 32'd1, 4, mg, mc); chk("model_sat", {mg, 32'(mc)}, {32'd1, 32'd15});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_gcd", bus.gcd_o, 0);
        chk("rst_cycles", bus.cycles_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(32'd48, 32'd18, 1); wait_done(g, c);
        chk("lit_48_18", {g, 24'(c)}, {32'd6, 24'd7});

        // asynchronous reset in the middle of a long reduction
        send(32'd1000, 32'd3, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_before_rst", bus.busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_busy", bus.busy_o, 0);
        chk("arst_res_valid", bus.res_valid, 0);
        chk("arst_gcd", bus.gcd_o, 0);
        chk("arst_cycles", bus.cycles_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_rst", bus.in_ready, 1);

        send(32'd7, 32'd7, 1);  wait_done(g, c); chk("lit_7_7", {g, 24'(c)}, {32'd7, 24'd2});
        send(32'd0, 32'd21, 1); wait_done(g, c); chk("lit_0_21", {g, 24'(c)}, {32'd21, 24'd0});
        send(32'd0, 32'd0, 1);  wait_done(g, c); chk("lit_0_0", {g, 24'(c)}, {32'd0, 24'd0});

        // backpressure: result must hold while extra operands are offered and ignored
        bus.res_ready = 0;
        send(32'd12, 32'd8, 1);
        for (int i = 0; i < 40 && !bus.res_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("bp_res_valid", bus.res_valid, 1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_gcd_hold", bus.gcd_o, 32'd4);
            bus.in_valid = i[0]; bus.a_i = 32'd99; bus.b_i = 32'd33;
            @(posedge clk); #1;
        end
        bus.in_valid = 0;
        bus.res_ready = 1;
        @(posedge clk); #1;
        chk("bp_release_idle", bus.in_ready, 1);

        // abort during reduction drops the result
        send(32'd1000, 32'd3, 0);
        @(posedge clk); #1;
        bus.abort_i = 1;
        @(posedge clk); #1;
        bus.abort_i = 0;
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_no_result", bus.res_valid, 0);
        send(32'd9, 32'd6, 1); wait_done(g, c);
        chk("lit_9_6", g, 32'd3);

        // narrow counter saturates on a long reduction
        bus2.in_valid = 1; bus2.a_i = 32'hFFFF_FFFF; bus2.b_i = 32'd1;
        @(posedge clk); #1;
        bus2.in_valid = 0;
        for (int i = 0; i < 200 && !bus2.res_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("sat_res_valid", bus2.res_valid, 1);
        chk("sat_gcd", bus2.gcd_o, 32'd1);
        chk("sat_cycles", bus2.cycles_o, 4'd15);

        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
